// File: rtl/full_hash_des_box_core.sv
// full_hash_des_box_core
// Streaming 32-bit hash built on DES S-box S1. Absorbs one byte per clock;
// the byte carrying a non-zero length ends the message, and the 64-bit
// length is folded in as eight extra rounds in a single finalization cycle.
// Note: rst_n is a synchronous, ACTIVE-HIGH reset despite its name.

module full_hash_des_box_core (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        M_valid,
   input  logic [7:0]  message,
   input  logic [63:0] counter,
   output logic [31:0] digest_out,
   output logic        hash_ready
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FINAL = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   // Packed IV {H0..H7}, H0 in the top nibble
   localparam logic [31:0] IV = 32'h4B71DF03;

   // DES S1 rows, column 0 in the top nibble
   localparam logic [63:0] S1_R0 = 64'hE4D12FB83A6C5907;
   localparam logic [63:0] S1_R1 = 64'h0F74E2D1A6CB9538;
   localparam logic [63:0] S1_R2 = 64'h41E8D62BFC973A50;
   localparam logic [63:0] S1_R3 = 64'hFC8249175B3EA06D;

   // Byte to 6-bit S-box input
   function automatic logic [5:0] f_c6(input logic [7:0] b);
      return {b[7] ^ b[1], b[3], b[2], b[5] ^ b[0], b[4], b[6]};
   endfunction

   // S1 lookup: row = {x5,x0}, column = x[4:1]
   function automatic logic [3:0] f_sbox(input logic [5:0] x);
      logic [63:0] row_bits;
      logic [63:0] shifted;
      case ({x[5], x[0]})
         2'd0:    row_bits = S1_R0;
         2'd1:    row_bits = S1_R1;
         2'd2:    row_bits = S1_R2;
         2'd3:    row_bits = S1_R3;
         default: row_bits = S1_R0;
      endcase
      shifted = row_bits << {x[4:1], 2'b00};
      return shifted[63:60];
   endfunction

   // 4-bit rotate left
   function automatic logic [3:0] f_rotl4(input logic [3:0] v, input logic [1:0] amt);
      logic [3:0] r;
      case (amt)
         2'd0:    r = v;
         2'd1:    r = {v[2:0], v[3]};
         2'd2:    r = {v[1:0], v[3:2]};
         2'd3:    r = {v[0], v[3:1]};
         default: r = v;
      endcase
      return r;
   endfunction

   // One round: every word takes its right neighbour xor S, rotated by j>>1
   function automatic logic [31:0] f_round(input logic [31:0] h, input logic [7:0] b);
      logic [3:0]  s;
      logic [3:0]  t;
      logic [31:0] r;
      s = f_sbox(f_c6(b));
      r = 32'h0000_0000;
      for (int j = 0; j < 8; j++) begin
         t = h[31 - 4*((j + 1) % 8) -: 4] ^ s;
         r[31 - 4*j -: 4] = f_rotl4(t, 2'(j >> 1));
      end
      return r;
   endfunction

   state_t      r_state;
   logic [31:0] r_h;
   logic [63:0] r_len;
   logic [31:0] r_digest;
   logic        r_ready;

   state_t      w_state_nxt;
   logic [31:0] w_h_nxt;
   logic [63:0] w_len_nxt;
   logic [31:0] w_digest_nxt;
   logic        w_ready_nxt;
   logic [31:0] w_abs;
   logic [31:0] w_fin;

   // Round datapaths: single absorb round and eight-round length fold
   always_comb begin
      w_abs = f_round(r_h, message);
      w_fin = r_h;
      for (int r = 0; r < 8; r++) begin
         w_fin = f_round(w_fin, r_len[8*r +: 8]);
      end
   end

   // Next-state and datapath control
   always_comb begin
      w_state_nxt  = r_state;
      w_h_nxt      = r_h;
      w_len_nxt    = r_len;
      w_digest_nxt = r_digest;
      w_ready_nxt  = r_ready;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (M_valid) begin
               // H already holds the IV in DONE, so a new message starts cleanly
               w_h_nxt     = w_abs;
               w_ready_nxt = 1'b0;
               if (counter != 64'd0) begin
                  w_len_nxt   = counter;
                  w_state_nxt = S_FINAL;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end else begin
               w_state_nxt = r_state;
            end
         end
         S_FINAL: begin
            // Input bytes are ignored here
            w_digest_nxt = w_fin;
            w_ready_nxt  = 1'b1;
            w_h_nxt      = IV;
            w_state_nxt  = S_DONE;
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_h_nxt     = IV;
            w_ready_nxt = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous active-high reset
   always_ff @(posedge clk) begin
      if (rst_n) begin
         r_state  <= S_IDLE;
         r_h      <= IV;
         r_len    <= 64'd0;
         r_digest <= 32'h0000_0000;
         r_ready  <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_h      <= w_h_nxt;
         r_len    <= w_len_nxt;
         r_digest <= w_digest_nxt;
         r_ready  <= w_ready_nxt;
      end
   end

   assign digest_out = r_digest;
   assign hash_ready = r_ready;

endmodule

// File: tb/tb_full_hash_des_box_core.sv
// Directed self-checking bench for full_hash_des_box_core.
// Reset is active-high on rst_n.

module tb_full_hash_des_box_core;

   logic        clk;
   logic        rst_n;
   logic        M_valid;
   logic [7:0]  message;
   logic [63:0] counter;
   logic [31:0] digest_out;
   logic        hash_ready;

   int n_tests = 0;
   int n_fail  = 0;

   // Hand-derived digest of "A" (0x41) with length 1
   localparam logic [31:0] DIG_A1 = 32'hF3F61E1A;

   int S1_TAB [0:3][0:15] = '{
      '{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7},
      '{ 0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8},
      '{ 4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0},
      '{15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13}
   };

   full_hash_des_box_core dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .M_valid    (M_valid),
      .message    (message),
      .counter    (counter),
      .digest_out (digest_out),
      .hash_ready (hash_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Golden model: n message bytes (byte k at msg[8k+7:8k]) then 8 length bytes
   function automatic logic [31:0] model_hash(input logic [31:0] msg, input int n,
                                              input logic [63:0] len);
      int h [8];
      int nh [8];
      int b, c, s, t, amt;
      logic [31:0] res;
      h = '{4, 11, 7, 1, 13, 15, 0, 3};
      for (int k = 0; k < n + 8; k++) begin
         if (k < n) b = int'(msg[8*k +: 8]);
         else       b = int'(len[8*(k-n) +: 8]);
         c = ((((b >> 7) ^ (b >> 1)) & 1) << 5) | (((b >> 3) & 1) << 4) |
             (((b >> 2) & 1) << 3) | ((((b >> 5) ^ b) & 1) << 2) |
             (((b >> 4) & 1) << 1) | ((b >> 6) & 1);
         s = S1_TAB[((c >> 4) & 2) | (c & 1)][(c >> 1) & 15];
         for (int j = 0; j < 8; j++) begin
            t   = h[(j + 1) % 8] ^ s;
            amt = j / 2;
            nh[j] = ((t << amt) | (t >> (4 - amt))) & 15;
         end
         h = nh;
      end
      res = 32'h0;
      for (int j = 0; j < 8; j++) res = {res[27:0], 4'(h[j])};
      return res;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b, input logic [63:0] c);
      M_valid = 1'b1;
      message = b;
      counter = c;
      @(posedge clk);
      #1;
      M_valid = 1'b0;
      message = 8'h00;
      counter = 64'd0;
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      repeat (2) tick();
      n_tests++;
      if (hash_ready !== 1'b0) begin
         n_fail++; $display("FAIL reset_ready: got %b expected 0", hash_ready);
      end
      n_tests++;
      if (digest_out !== 32'h0000_0000) begin
         n_fail++; $display("FAIL reset_digest: got %h expected 00000000", digest_out);
      end
      rst_n = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         n_tests++;
         if (hash_ready !== 1'b0 || digest_out !== 32'h0000_0000) begin
            n_fail++;
            $display("FAIL idle_hold: got ready=%b digest=%h expected 0/00000000", hash_ready, digest_out);
         end
      end
   endtask

   task automatic test_single_a();
      send(8'h41, 64'd1);
      n_tests++;
      if (hash_ready !== 1'b0) begin
         n_fail++; $display("FAIL single_a_early: got ready=%b expected 0", hash_ready);
      end
      tick();
      n_tests++;
      if (hash_ready !== 1'b1) begin
         n_fail++; $display("FAIL single_a_ready: got %b expected 1", hash_ready);
      end
      n_tests++;
      if (digest_out !== DIG_A1) begin
         n_fail++; $display("FAIL single_a_digest: got %h expected %h", digest_out, DIG_A1);
      end
      n_tests++;
      if (DIG_A1 !== model_hash(32'h41, 1, 64'd1)) begin
         n_fail++; $display("FAIL single_a_model: got %h expected %h", model_hash(32'h41, 1, 64'd1), DIG_A1);
      end
      for (int i = 0; i < 10; i++) begin
         tick();
         n_tests++;
         if (hash_ready !== 1'b1 || digest_out !== DIG_A1) begin
            n_fail++;
            $display("FAIL single_a_hold: got ready=%b digest=%h expected 1/%h", hash_ready, digest_out, DIG_A1);
         end
      end
   endtask

   task automatic test_abc();
      logic [31:0] exp_a;
      logic [31:0] exp_abc;
      logic [31:0] dig_a;
      exp_a   = model_hash(32'h0000_0061, 1, 64'd1);
      exp_abc = model_hash(32'h0063_6261, 3, 64'd3);
      send(8'h61, 64'd1);
      tick();
      dig_a = digest_out;
      n_tests++;
      if (dig_a !== exp_a) begin
         n_fail++; $display("FAIL a_digest: got %h expected %h", dig_a, exp_a);
      end
      send(8'h61, 64'd0);
      n_tests++;
      if (hash_ready !== 1'b0) begin
         n_fail++; $display("FAIL abc_ready_clear: got %b expected 0", hash_ready);
      end
      send(8'h62, 64'd0);
      send(8'h63, 64'd3);
      n_tests++;
      if (hash_ready !== 1'b0) begin
         n_fail++; $display("FAIL abc_early: got %b expected 0", hash_ready);
      end
      tick();
      n_tests++;
      if (hash_ready !== 1'b1) begin
         n_fail++; $display("FAIL abc_ready: got %b expected 1", hash_ready);
      end
      n_tests++;
      if (digest_out !== exp_abc) begin
         n_fail++; $display("FAIL abc_digest: got %h expected %h", digest_out, exp_abc);
      end
      n_tests++;
      if (digest_out === dig_a) begin
         n_fail++; $display("FAIL abc_vs_a: got %h expected value different from %h", digest_out, dig_a);
      end
   endtask

   task automatic test_back_to_back();
      send(8'h41, 64'd1);
      tick();
      n_tests++;
      if (hash_ready !== 1'b1 || digest_out !== DIG_A1) begin
         n_fail++; $display("FAIL b2b_first: got ready=%b digest=%h expected 1/%h", hash_ready, digest_out, DIG_A1);
      end
      send(8'h41, 64'd1);
      n_tests++;
      if (hash_ready !== 1'b0) begin
         n_fail++; $display("FAIL b2b_drop: got %b expected 0", hash_ready);
      end
      tick();
      n_tests++;
      if (hash_ready !== 1'b1 || digest_out !== DIG_A1) begin
         n_fail++; $display("FAIL b2b_second: got ready=%b digest=%h expected 1/%h", hash_ready, digest_out, DIG_A1);
      end
   endtask

   task automatic test_final_drop();
      send(8'h41, 64'd1);
      // byte offered during the finalization cycle must be ignored
      send(8'h55, 64'd5);
      n_tests++;
      if (hash_ready !== 1'b1 || digest_out !== DIG_A1) begin
         n_fail++; $display("FAIL final_drop: got ready=%b digest=%h expected 1/%h", hash_ready, digest_out, DIG_A1);
      end
      tick();
      n_tests++;
      if (hash_ready !== 1'b1 || digest_out !== DIG_A1) begin
         n_fail++; $display("FAIL final_drop_hold: got ready=%b digest=%h expected 1/%h", hash_ready, digest_out, DIG_A1);
      end
   endtask

   task automatic test_length();
      logic [31:0] exp_l;
      exp_l = model_hash(32'h41, 1, 64'h0000_0001_0000_0001);
      send(8'h41, 64'h0000_0001_0000_0001);
      tick();
      n_tests++;
      if (digest_out !== exp_l) begin
         n_fail++; $display("FAIL length_digest: got %h expected %h", digest_out, exp_l);
      end
      n_tests++;
      if (digest_out === DIG_A1) begin
         n_fail++; $display("FAIL length_sensitivity: got %h expected value different from %h", digest_out, DIG_A1);
      end
   endtask

   task automatic test_mid_reset();
      send(8'h12, 64'd0);
      send(8'h34, 64'd0);
      rst_n = 1'b1;
      tick();
      rst_n = 1'b0;
      n_tests++;
      if (hash_ready !== 1'b0 || digest_out !== 32'h0000_0000) begin
         n_fail++; $display("FAIL mid_reset_clear: got ready=%b digest=%h expected 0/00000000", hash_ready, digest_out);
      end
      send(8'h41, 64'd1);
      tick();
      n_tests++;
      if (hash_ready !== 1'b1 || digest_out !== DIG_A1) begin
         n_fail++; $display("FAIL mid_reset_digest: got ready=%b digest=%h expected 1/%h", hash_ready, digest_out, DIG_A1);
      end
      // reset landing on the finalization edge wins
      send(8'h41, 64'd1);
      rst_n = 1'b1;
      tick();
      rst_n = 1'b0;
      n_tests++;
      if (hash_ready !== 1'b0 || digest_out !== 32'h0000_0000) begin
         n_fail++; $display("FAIL final_reset: got ready=%b digest=%h expected 0/00000000", hash_ready, digest_out);
      end
      tick();
      n_tests++;
      if (hash_ready !== 1'b0 || digest_out !== 32'h0000_0000) begin
         n_fail++; $display("FAIL final_reset_hold: got ready=%b digest=%h expected 0/00000000", hash_ready, digest_out);
      end
   endtask

   initial begin
      rst_n   = 1'b1;
      M_valid = 1'b0;
      message = 8'h00;
      counter = 64'd0;
      test_reset();
      test_single_a();
      test_abc();
      test_back_to_back();
      test_final_drop();
      test_length();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
